// File: rtl/fpnew_pkg.sv
// Shared FP-format definitions and the arbiter state type used by fma_share_arbiter.
package fpnew_pkg;

    localparam int unsigned NUM_FP_FORMATS = 5;
    localparam int unsigned FP_FORMAT_BITS = 3;

    typedef enum logic [FP_FORMAT_BITS-1:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o
);

    logic [31:0] w_cand;
    logic        w_found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int unsigned off = 0; off < N; off++) begin
            w_cand = (32'(ptr_i) + off) % 32'(N);
            if (!w_found && eligible_i[w_cand]) begin
                grant_o[w_cand] = 1'b1;
                idx_o           = w_cand[PW-1:0];
                w_found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fma_share_arbiter.sv
// Shares one FMA pipeline among NUM_REQ requesters: round-robin issue, per-requester credits, tag routing, flush/drain.
// Define FMA_ARB_STATS_EN to add grant_cnt_o (per-requester 16-bit wrapping issue counters).
module fma_share_arbiter
    import fpnew_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 64,
    parameter int MAX_OUT = 4,
    localparam int TAG_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*3*WIDTH-1:0] req_operands_i,
    input  logic [NUM_REQ*3-1:0]       req_fmt_i,
    output logic                       fma_valid_o,
    input  logic                       fma_ready_i,
    output logic [3*WIDTH-1:0]         fma_operands_o,
    output logic [2:0]                 fma_fmt_o,
    output logic [TAG_W-1:0]           fma_tag_o,
    input  logic                       fma_res_valid_i,
    output logic                       fma_res_ready_o,
    input  logic [WIDTH-1:0]           fma_res_i,
    input  logic [TAG_W-1:0]           fma_res_tag_i,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    input  logic [NUM_REQ-1:0]         rsp_ready_i,
    output logic [WIDTH-1:0]           rsp_result_o,
    input  logic                       flush_i,
    output logic                       flush_done_o,
    output logic                       busy_o,
    output logic                       err_o
`ifdef FMA_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]      grant_cnt_o
`endif
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_OUT);
    localparam logic [TAG_W-1:0] LAST_T = TAG_W'(NUM_REQ - 1);

    arb_state_e       r_state, w_state_nxt;
    logic [TAG_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt     [NUM_REQ];
    logic [CNT_W-1:0] w_cnt_nxt [NUM_REQ];
    logic             r_err;

    logic [NUM_REQ-1:0] w_elig, w_grant;
    logic [TAG_W-1:0]   w_idx;
    logic               w_issue, w_tag_ok, w_rdy_sel, w_stray, w_res_hs;
    logic               w_all_zero, w_any_cnt;
    logic [CNT_W-1:0]   w_cnt_sel;
    fp_format_e         w_fmt;

    always_comb begin
        w_elig = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++)
            w_elig[r] = req_valid_i[r] && (r_cnt[r] < MAX_C) && (r_state != DRAIN);
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .eligible_i (w_elig),
        .ptr_i      (r_ptr),
        .grant_o    (w_grant),
        .idx_o      (w_idx)
    );

    assign fma_valid_o = |w_elig;
    assign w_issue     = fma_valid_o && fma_ready_i;
    assign req_ready_o = w_grant & {NUM_REQ{fma_ready_i}};
    assign fma_tag_o   = w_idx;
    assign fma_fmt_o   = w_fmt;

    always_comb begin
        fma_operands_o = '0;
        w_fmt          = FP32;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (w_grant[r]) begin
                fma_operands_o = req_operands_i[r*3*WIDTH +: 3*WIDTH];
                w_fmt          = fp_format_e'(req_fmt_i[r*3 +: 3]);
            end
        end
    end

    // Tag decode by comparison so out-of-range tags never index past the arrays.
    always_comb begin
        w_tag_ok  = 1'b0;
        w_cnt_sel = '0;
        w_rdy_sel = 1'b0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (fma_res_tag_i == TAG_W'(r)) begin
                w_tag_ok  = 1'b1;
                w_cnt_sel = r_cnt[r];
                w_rdy_sel = rsp_ready_i[r];
            end
        end
    end

    assign w_stray         = fma_res_valid_i && (!w_tag_ok || (w_cnt_sel == '0));
    assign w_res_hs        = fma_res_valid_i && !w_stray && w_rdy_sel;
    assign fma_res_ready_o = w_stray || w_rdy_sel;
    assign rsp_result_o    = fma_res_i;

    always_comb begin
        rsp_valid_o = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++)
            rsp_valid_o[r] = fma_res_valid_i && !w_stray && (fma_res_tag_i == TAG_W'(r));
    end

    always_comb begin
        w_all_zero = 1'b1;
        w_any_cnt  = 1'b0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            w_cnt_nxt[r] = r_cnt[r];
            if (w_issue && w_grant[r] && !(w_res_hs && rsp_valid_o[r]) && (r_cnt[r] != MAX_C))
                w_cnt_nxt[r] = r_cnt[r] + CNT_W'(1);
            else if (w_res_hs && rsp_valid_o[r] && !(w_issue && w_grant[r]) && (r_cnt[r] != '0))
                w_cnt_nxt[r] = r_cnt[r] - CNT_W'(1);
            if (w_cnt_nxt[r] != '0) w_all_zero = 1'b0;
            if (r_cnt[r] != '0)     w_any_cnt  = 1'b1;
        end
    end

    // Idle/done decisions look at post-update counts so the last completing result ends the drain.
    always_comb begin
        w_state_nxt  = r_state;
        flush_done_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (flush_i)      w_state_nxt = DRAIN;
                else if (w_issue) w_state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (flush_i)         w_state_nxt = DRAIN;
                else if (w_all_zero) w_state_nxt = IDLE;
            end
            DRAIN: begin
                if (!flush_i && w_all_zero) begin
                    w_state_nxt  = IDLE;
                    flush_done_o = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_err   <= 1'b0;
            for (int unsigned r = 0; r < NUM_REQ; r++) r_cnt[r] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) r_ptr <= (w_idx == LAST_T) ? '0 : w_idx + TAG_W'(1);
            if (w_stray) r_err <= 1'b1;
            for (int unsigned r = 0; r < NUM_REQ; r++) r_cnt[r] <= w_cnt_nxt[r];
        end
    end

    assign busy_o = w_any_cnt || (r_state != IDLE);
    assign err_o  = r_err;

`ifdef FMA_ARB_STATS_EN
    logic [15:0] r_grant_cnt [NUM_REQ];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned r = 0; r < NUM_REQ; r++) r_grant_cnt[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REQ; r++)
                if (w_issue && w_grant[r]) r_grant_cnt[r] <= r_grant_cnt[r] + 16'd1;
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) grant_cnt_o[r*16 +: 16] = r_grant_cnt[r];
    end
`endif

endmodule
